mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, address width; DATA_W, default 8, data width.
REQ-002 Port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port f_req  input  1  fetch-stage read request; f_addr  input  ADDR_W  fetch address.
REQ-005 Port f_gnt  output  1  fetch request accepted this cycle.
REQ-006 Port f_rvalid  output  1  f_rdata is valid; f_rdata  output  DATA_W  fetch read data.
REQ-007 Port d_req  input  1  data-stage request; d_we  input  1  write when 1, read when 0.
REQ-008 Port d_addr  input  ADDR_W and d_wdata  input  DATA_W  data-stage address and write data.
REQ-009 Port d_gnt  output  1  data request accepted; d_rvalid  output  1  d_rdata valid; d_rdata  output  DATA_W.
REQ-010 Port mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_we  output  1  single-port synchronous RAM drive.
REQ-011 Port mem_rdata  input  DATA_W  RAM read data, valid one cycle after the address is presented.

Function
REQ-012 The arbiter SHALL grant at most one requester per cycle; f_gnt and d_gnt SHALL never be 1 together.
REQ-013 A grant SHALL be combinational in the request cycle N; mem_addr, mem_wdata and mem_we SHALL be driven from the granted requester in cycle N.
REQ-014 With no grant, mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold their last granted values.
REQ-015 A granted read SHALL assert the owner's rvalid for exactly cycle N+1, with rdata equal to mem_rdata.
REQ-016 A granted write SHALL assert mem_we in cycle N only and SHALL NOT produce any rvalid.
REQ-017 Reads SHALL be pipelined: back-to-back grants in N and N+1 SHALL yield rvalid in N+1 and N+2, with no bubble.
REQ-018 f_rdata and d_rdata SHALL be mem_rdata when the corresponding rvalid is 0 (don't-care); rvalid is the only qualifier.
REQ-019 A requester not granted SHALL hold req and its address/data stable; the arbiter does not latch denied requests.
REQ-020 If only one requester asserts req, it SHALL be granted in that cycle.
REQ-021 A 1-bit register last_owner SHALL record the most recent grantee (0 = fetch, 1 = data).
REQ-022 Requests to the same address by both requesters SHALL be arbitrated normally; no forwarding between them.

Reset
REQ-023 While rst is 1 at a rising edge: f_gnt=d_gnt=0, f_rvalid=d_rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, last_owner=0.
REQ-024 A read granted in the cycle rst rises SHALL NOT produce rvalid in the following cycle.
REQ-025 Grants SHALL resume in the first cycle with rst low.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted to the requester that is not last_owner (alternating).
REQ-027 Without MEM_ARB_RR_EN, simultaneous requests SHALL always grant data (fixed priority); fetch may starve.

Structure
REQ-028 ADDR_W/DATA_W defaults and the owner encoding (OWNER_FETCH=0, OWNER_DATA=1) SHALL live in the shared core package.
REQ-029 The block SHALL be a single module; the grant-select logic may be a sub-module arb_select (combinational plus last_owner register).

Verification
REQ-030 Fetch-only read: mem[0x00]=0x50, f_req=1, f_addr=0x00 -> f_gnt=1 in N, f_rvalid=1, f_rdata=0x50 in N+1.
REQ-031 Data write then fetch read: d_we=1, d_addr=0xE0, d_wdata=0x01 in N -> mem_we=1 in N, no rvalid; f_addr=0xE0 in N+1 -> f_rdata=0x01 in N+2.
REQ-032 Contention, RR undefined: both req for 4 cycles -> d_gnt=1 in all 4 cycles, f_gnt=0.
REQ-033 Contention, MEM_ARB_RR_EN defined, after reset: both req for 4 cycles -> grants D,F,D,F.
REQ-034 Streaming: f_req held for 8 cycles, addr 0x00..0x07 -> 8 consecutive f_rvalid, data in address order, no gaps.
REQ-035 Reset mid-read: grant read at 0x02, rst=1 next edge -> f_rvalid=0 and mem_we=0 after that edge; normal grant on the first cycle with rst low.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: default widths and owner encoding.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Grant selection between the fetch and data requesters, plus the last_owner record.
// Build option: define MEM_ARB_RR_EN for alternating grants on contention (default: data wins).
module arb_select
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic f_req,
    input  logic d_req,
    output logic f_gnt,
    output logic d_gnt
);

    owner_e last_owner;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                if (last_owner == OWNER_DATA) begin
                    f_gnt = 1'b1;
                end else begin
                    d_gnt = 1'b1;
                end
`else
                d_gnt = 1'b1;
`endif
            end else begin
                f_gnt = f_req;
                d_gnt = d_req;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWNER_FETCH;
        end else if (f_gnt) begin
            last_owner <= OWNER_FETCH;
        end else if (d_gnt) begin
            last_owner <= OWNER_DATA;
        end
    end

`ifndef MEM_ARB_RR_EN
    // With fixed priority the owner record is kept but never consulted.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch read-only, data read/write) in front of a single-port synchronous RAM.
// Build option: MEM_ARB_RR_EN selects round-robin contention handling in arb_select.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    arb_select u_sel (
        .clk   (clk),
        .rst   (rst),
        .f_req (f_req),
        .d_req (d_req),
        .f_gnt (f_gnt),
        .d_gnt (d_gnt)
    );

    // The RAM bus follows the granted requester; when idle it parks on the last granted values.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end else if (f_gnt) begin
            mem_addr  = f_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            if (f_gnt || d_gnt) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt && !d_we;
        end
    end

    // Read data is shared; each rvalid alone says whose it is.
    assign f_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, d_req, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          f_gnt, d_gnt, f_rvalid, d_rvalid;
    logic [DW-1:0] f_rdata, d_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM: one-cycle read latency, read returns the pre-write contents.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    // Apply one cycle of requests at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic fr, input logic [AW-1:0] fa, input logic dr, input logic dwe,
                         input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        @(negedge clk);
        f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        f_req = 1'b1; f_addr = 8'h33; d_req = 1'b1; d_we = 1'b1; d_addr = 8'hAA; d_wdata = 8'h55;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (f_gnt !== 1'b0)     begin errors++; $display("FAIL reset_f_gnt got %b want 0", f_gnt); end
        checks++; if (d_gnt !== 1'b0)     begin errors++; $display("FAIL reset_d_gnt got %b want 0", d_gnt); end
        checks++; if (f_rvalid !== 1'b0)  begin errors++; $display("FAIL reset_f_rvalid got %b want 0", f_rvalid); end
        checks++; if (d_rvalid !== 1'b0)  begin errors++; $display("FAIL reset_d_rvalid got %b want 0", d_rvalid); end
        checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %h want 00", mem_wdata); end
        // First cycle with rst low: contention after reset goes to data in either build.
        rst = 1'b0;
        #1;
        checks++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0)
            begin errors++; $display("FAIL resume_gnt got f=%b d=%b want f=0 d=1", f_gnt, d_gnt); end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'hAA || mem_wdata !== 8'h55)
            begin errors++; $display("FAIL resume_bus got we=%b a=%h wd=%h want 1 AA 55", mem_we, mem_addr, mem_wdata); end
        ref_mem[8'hAA] = 8'h55;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (d_rvalid !== 1'b0 || f_rvalid !== 1'b0)
            begin errors++; $display("FAIL resume_write_rvalid got f=%b d=%b want 0 0", f_rvalid, d_rvalid); end
    endtask

    task automatic test_fetch_read();
        preload(8'h00, 8'h50);
        drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0)
            begin errors++; $display("FAIL fetch_gnt got f=%b d=%b want 1 0", f_gnt, d_gnt); end
        checks++; if (mem_addr !== 8'h00 || mem_we !== 1'b0)
            begin errors++; $display("FAIL fetch_bus got a=%h we=%b want 00 0", mem_addr, mem_we); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0)
            begin errors++; $display("FAIL fetch_rvalid got f=%b d=%b want 1 0", f_rvalid, d_rvalid); end
        checks++; if (f_rdata !== 8'h50) begin errors++; $display("FAIL fetch_rdata got %h want 50", f_rdata); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_once got %b want 0", f_rvalid); end
    endtask

    task automatic test_write_then_read();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hE0, 8'h01);
        checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'hE0 || mem_wdata !== 8'h01)
            begin errors++; $display("FAIL write_bus got g=%b we=%b a=%h wd=%h want 1 1 E0 01", d_gnt, mem_we, mem_addr, mem_wdata); end
        ref_mem[8'hE0] = 8'h01;
        drive(1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0)
            begin errors++; $display("FAIL write_no_rvalid got f=%b d=%b want 0 0", f_rvalid, d_rvalid); end
        checks++; if (f_gnt !== 1'b1 || mem_we !== 1'b0)
            begin errors++; $display("FAIL wr_fetch_gnt got g=%b we=%b want 1 0", f_gnt, mem_we); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 8'h01)
            begin errors++; $display("FAIL wr_fetch_rdata got v=%b d=%h want 1 01", f_rvalid, f_rdata); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'hE0)
            begin errors++; $display("FAIL idle_hold got we=%b a=%h want 0 E0", mem_we, mem_addr); end
    endtask

    task automatic test_contention();
        logic          exp_d;
        logic          prev_d;
        logic [AW-1:0] prev_a;
        apply_reset();
        prev_d = 1'b0; prev_a = '0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 8'(8'h20 + i), 8'h00);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
            if (i > 0) begin
                checks++; if (f_rvalid !== !prev_d || d_rvalid !== prev_d || mem_rdata !== ref_mem[prev_a])
                    begin errors++; $display("FAIL contend_rvalid[%0d] got f=%b d=%b data=%h want f=%b d=%b data=%h",
                        i, f_rvalid, d_rvalid, mem_rdata, !prev_d, prev_d, ref_mem[prev_a]); end
            end
            if (i < 4) begin
`ifdef MEM_ARB_RR_EN
                exp_d = (i % 2 == 0);
`else
                exp_d = 1'b1;
`endif
                checks++; if (d_gnt !== exp_d || f_gnt !== !exp_d)
                    begin errors++; $display("FAIL contend_gnt[%0d] got f=%b d=%b want f=%b d=%b", i, f_gnt, d_gnt, !exp_d, exp_d); end
                prev_d = exp_d;
                prev_a = exp_d ? 8'(8'h20 + i) : 8'(8'h10 + i);
            end
        end
    endtask

    task automatic test_streaming();
        for (int a = 0; a < 8; a++) preload(8'(a), 8'($urandom));
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00, 8'h00);
            else       drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
            if (i < 8) begin
                checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL stream_gnt[%0d] got %b want 1", i, f_gnt); end
            end
            if (i > 0) begin
                checks++; if (f_rvalid !== 1'b1 || f_rdata !== ref_mem[i-1])
                    begin errors++; $display("FAIL stream_data[%0d] got v=%b d=%h want 1 %h", i - 1, f_rvalid, f_rdata, ref_mem[i-1]); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        preload(8'h02, 8'hC3);
        drive(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL midrst_gnt got %b want 1", f_gnt); end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (f_rvalid !== 1'b0 || mem_we !== 1'b0 || f_gnt !== 1'b0)
            begin errors++; $display("FAIL midrst_suppress got v=%b we=%b g=%b want 0 0 0", f_rvalid, mem_we, f_gnt); end
        rst = 1'b0;
        #1;
        checks++; if (f_gnt !== 1'b1 || mem_addr !== 8'h02)
            begin errors++; $display("FAIL midrst_resume got g=%b a=%h want 1 02", f_gnt, mem_addr); end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 8'hC3)
            begin errors++; $display("FAIL midrst_rdata got v=%b d=%h want 1 C3", f_rvalid, f_rdata); end
    endtask

    // Random traffic; denied requests stay pending unchanged until granted.
    task automatic test_random();
        logic          fp, dp, dwe, gf, gd, last_d, exp_frv, exp_drv;
        logic [AW-1:0] fa, da, hold_a, exp_a;
        logic [DW-1:0] dwd, exp_rd;
        apply_reset();
        fp = 1'b0; dp = 1'b0; dwe = 1'b0; fa = '0; da = '0; dwd = '0;
        last_d = 1'b0; exp_frv = 1'b0; exp_drv = 1'b0; exp_rd = '0; hold_a = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!fp && $urandom_range(0, 2) != 0) begin fp = 1'b1; fa = 8'($urandom_range(0, 15)); end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1'b1; dwe = ($urandom_range(0, 1) == 1); da = 8'($urandom_range(0, 15)); dwd = 8'($urandom);
            end
            drive(fp, fa, dp, dwe, da, dwd);
            checks++; if (f_rvalid !== exp_frv || d_rvalid !== exp_drv)
                begin errors++; $display("FAIL rand_rvalid[%0d] got f=%b d=%b want f=%b d=%b", cyc, f_rvalid, d_rvalid, exp_frv, exp_drv); end
            if (exp_frv || exp_drv) begin
                checks++; if ((exp_frv ? f_rdata : d_rdata) !== exp_rd)
                    begin errors++; $display("FAIL rand_rdata[%0d] got %h want %h", cyc, exp_frv ? f_rdata : d_rdata, exp_rd); end
            end
`ifdef MEM_ARB_RR_EN
            gd = dp && (!fp || !last_d);
`else
            gd = dp;
`endif
            gf = fp && !gd;
            exp_a = gd ? da : (gf ? fa : hold_a);
            checks++; if (f_gnt !== gf || d_gnt !== gd)
                begin errors++; $display("FAIL rand_gnt[%0d] got f=%b d=%b want f=%b d=%b", cyc, f_gnt, d_gnt, gf, gd); end
            checks++; if (mem_we !== (gd && dwe) || mem_addr !== exp_a)
                begin errors++; $display("FAIL rand_bus[%0d] got we=%b a=%h want we=%b a=%h", cyc, mem_we, mem_addr, gd && dwe, exp_a); end
            if (gd) begin
                checks++; if (mem_wdata !== dwd)
                    begin errors++; $display("FAIL rand_wdata[%0d] got %h want %h", cyc, mem_wdata, dwd); end
            end
            exp_frv = gf;
            exp_drv = gd && !dwe;
            if (gf) exp_rd = ref_mem[fa];
            if (gd && !dwe) exp_rd = ref_mem[da];
            if (gd && dwe) ref_mem[da] = dwd;
            if (gf || gd) begin hold_a = exp_a; last_d = gd; end
            if (gf) fp = 1'b0;
            if (gd) dp = 1'b0;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++; if (f_rvalid !== exp_frv || d_rvalid !== exp_drv)
            begin errors++; $display("FAIL rand_tail got f=%b d=%b want f=%b d=%b", f_rvalid, d_rvalid, exp_frv, exp_drv); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) preload(8'(a), 8'($urandom));
        test_reset();
        test_fetch_read();
        test_write_then_read();
        test_contention();
        test_streaming();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
